// File: rtl/unified_memory_arbiter.sv
// Single-ported memory shared between instruction fetch and data access.
// Sequences fixed-latency accesses and produces the pipeline stall controls.
module unified_memory_arbiter #(
  parameter int LATENCY      = 2,
  parameter int MAX_DATA_RUN = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              pipe_hold
);
  localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [RUN_W-1:0]  run;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic              dreq, cmpl, decide, grant_d, grant_f, run_ok, stall;

  assign dreq    = dm_read | dm_write;
  assign cmpl    = (state != IDLE) && (cnt == 4'd0);
  assign decide  = (state == IDLE) || cmpl;
  assign run_ok  = run < RUN_W'(MAX_DATA_RUN);
  // Data wins unless it has hogged the port while a fetch waits.
  assign grant_d = decide && dreq && (!if_req || run_ok);
  assign grant_f = decide && !grant_d && if_req;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      run      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if (grant_d) begin
        state   <= DATA;
        addr_q  <= dm_addr;
        wdata_q <= dm_wdata;
        we_q    <= dm_write;
        cnt     <= 4'(LATENCY - 1);
      end else if (grant_f) begin
        state   <= FETCH;
        addr_q  <= if_addr;
        we_q    <= 1'b0;
        cnt     <= 4'(LATENCY - 1);
      end else if (decide) begin
        state   <= IDLE;
      end else begin
        cnt     <= cnt - 4'd1;
      end

      if (!if_req || grant_f)
        run <= '0;
      else if (grant_d && run_ok)
        run <= run + 1'b1;

      if (cmpl && state == FETCH)
        if_rdata <= mem_rdata;
      if (cmpl && state == DATA && !we_q)
        dm_rdata <= mem_rdata;
    end
  end

  assign if_done   = cmpl && (state == FETCH);
  assign dm_done   = cmpl && (state == DATA);
  assign mem_en    = (state != IDLE);
  assign mem_we    = (state == DATA) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Held in reset the pipeline must be free-running, whatever the requests say.
  assign stall       = RST & ((if_req & ~if_done) | (dreq & ~dm_done));
  assign pc_write    = ~stall;
  assign if_id_write = ~stall;
  assign pipe_hold   = stall;
endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Bench for unified_memory_arbiter: three instances (LATENCY 2, 3, 1) with a
// completion scoreboard plus per-scenario cycle checks.
module tb_unified_memory_arbiter;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst_n[3], if_req[3], dm_read[3], dm_write[3];
  logic [31:0] if_addr[3], dm_addr[3], dm_wdata[3], mem_rdata[3];
  logic [31:0] if_rdata[3], dm_rdata[3], mem_addr[3], mem_wdata[3];
  logic        if_done[3], dm_done[3], mem_en[3], mem_we[3];
  logic        pc_write[3], if_id_write[3], pipe_hold[3];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h8C220004;
      32'h20:  return 32'h55;
      default: return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    unified_memory_arbiter #(
      .LATENCY(g == 0 ? 2 : (g == 1 ? 3 : 1)), .MAX_DATA_RUN(4), .ADDR_W(32)
    ) u_dut (
      .CLK(CLK), .RST(rst_n[g]),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]), .if_done(if_done[g]),
      .dm_read(dm_read[g]), .dm_write(dm_write[g]), .dm_addr(dm_addr[g]), .dm_wdata(dm_wdata[g]),
      .dm_rdata(dm_rdata[g]), .dm_done(dm_done[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]),
      .pc_write(pc_write[g]), .if_id_write(if_id_write[g]), .pipe_hold(pipe_hold[g])
    );
    assign mem_rdata[g] = mem_fn(mem_addr[g]);
  end

  typedef struct {
    int          g;
    bit          data;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sbq[$];
  exp_t        pe;
  bit          pend = 1'b0;
  int          n_chk = 0, n_fail = 0;
  logic [31:0] dm_hold[3];
  logic [31:0] got, want;

  // Scoreboard: every done pulse consumes one expected access; the registered
  // read data is checked on the following cycle.
  always @(negedge CLK) begin
    if (pend) begin
      pend = 1'b0;
      if (pe.data) begin
        got  = dm_rdata[pe.g];
        want = pe.we ? dm_hold[pe.g] : pe.rdata;
        if (!pe.we) dm_hold[pe.g] = pe.rdata;
      end else begin
        got  = if_rdata[pe.g];
        want = pe.rdata;
      end
      n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL sb_rdata inst=%0d data=%0b got=%h want=%h", pe.g, pe.data, got, want); end
    end
    for (int g = 0; g < 3; g++) begin
      if (if_done[g] || dm_done[g]) begin
        n_chk++;
        if (sbq.size() == 0) begin
          n_fail++; $display("FAIL sb_unexpected inst=%0d if_done=%0b dm_done=%0b", g, if_done[g], dm_done[g]);
        end else begin
          pe = sbq.pop_front();
          pend = 1'b1;
          if (pe.g != g || pe.data !== dm_done[g] || mem_addr[g] !== pe.addr || mem_we[g] !== pe.we ||
              (pe.we && mem_wdata[g] !== pe.wdata)) begin
            n_fail++;
            $display("FAIL sb_access got inst=%0d data=%0b addr=%h we=%0b wdata=%h want inst=%0d data=%0b addr=%h we=%0b wdata=%h",
                     g, dm_done[g], mem_addr[g], mem_we[g], mem_wdata[g], pe.g, pe.data, pe.addr, pe.we, pe.wdata);
          end
        end
      end
    end
  end

  task automatic test_reset();
    int t;
    repeat (2) @(negedge CLK);
    n_chk++; if (mem_en[0] !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en got=%0b want=0", mem_en[0]); end
    n_chk++; if (mem_addr[0] !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr got=%h want=0", mem_addr[0]); end
    n_chk++; if (pc_write[0] !== 1'b1 || if_id_write[0] !== 1'b1) begin n_fail++; $display("FAIL rst_pc_write got=%0b/%0b want=1/1", pc_write[0], if_id_write[0]); end
    n_chk++; if (pipe_hold[0] !== 1'b0) begin n_fail++; $display("FAIL rst_pipe_hold got=%0b want=0", pipe_hold[0]); end
    n_chk++; if (if_rdata[0] !== 32'h0 || dm_rdata[0] !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got=%h/%h want=0/0", if_rdata[0], dm_rdata[0]); end
    for (int g = 0; g < 3; g++) rst_n[g] = 1'b1;
    @(negedge CLK);
    dm_read[0] = 1'b1; dm_addr[0] = 32'h30;
    sbq.push_back('{0, 1'b1, 1'b0, 32'h30, 32'h0, mem_fn(32'h30)});
    t = 0;
    do begin @(negedge CLK); t++; end while (!dm_done[0] && t < 8);
    n_chk++; if (dm_done[0] !== 1'b1) begin n_fail++; $display("FAIL rst_pre_read_timeout got=%0b want=1", dm_done[0]); end
    dm_read[0] = 1'b0;
    @(negedge CLK);
    dm_write[0] = 1'b1; dm_addr[0] = 32'h40; dm_wdata[0] = 32'h12345678;
    @(negedge CLK);
    n_chk++; if (mem_we[0] !== 1'b1) begin n_fail++; $display("FAIL rst_pre_write_we got=%0b want=1", mem_we[0]); end
    #2 rst_n[0] = 1'b0;
    #1;
    n_chk++; if (mem_en[0] !== 1'b0 || mem_we[0] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_mem got en=%0b we=%0b want 0/0", mem_en[0], mem_we[0]); end
    n_chk++; if (if_done[0] !== 1'b0 || dm_done[0] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got=%0b/%0b want=0/0", if_done[0], dm_done[0]); end
    n_chk++; if (pc_write[0] !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pc_write got=%0b want=1", pc_write[0]); end
    n_chk++; if (if_rdata[0] !== 32'h0 || dm_rdata[0] !== 32'h0) begin n_fail++; $display("FAIL rst_mid_rdata got=%h/%h want=0/0", if_rdata[0], dm_rdata[0]); end
    dm_write[0] = 1'b0;
    dm_hold[0]  = 32'h0;
    @(negedge CLK);
    rst_n[0] = 1'b1;
  endtask

  task automatic test_single_fetch();
    if_req[0] = 1'b1; if_addr[0] = 32'h10;
    sbq.push_back('{0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h8C220004});
    @(negedge CLK);
    n_chk++; if (mem_en[0] !== 1'b1 || mem_addr[0] !== 32'h10 || mem_we[0] !== 1'b0) begin n_fail++; $display("FAIL fetch_c1_mem got en=%0b addr=%h we=%0b want 1/10/0", mem_en[0], mem_addr[0], mem_we[0]); end
    n_chk++; if (if_done[0] !== 1'b0 || pc_write[0] !== 1'b0) begin n_fail++; $display("FAIL fetch_c1_stall got done=%0b pc_write=%0b want 0/0", if_done[0], pc_write[0]); end
    if_addr[0] = 32'h99;
    @(negedge CLK);
    n_chk++; if (mem_en[0] !== 1'b1 || mem_addr[0] !== 32'h10) begin n_fail++; $display("FAIL fetch_c2_mem got en=%0b addr=%h want 1/10", mem_en[0], mem_addr[0]); end
    n_chk++; if (if_done[0] !== 1'b1 || pc_write[0] !== 1'b1) begin n_fail++; $display("FAIL fetch_c2_done got done=%0b pc_write=%0b want 1/1", if_done[0], pc_write[0]); end
    if_req[0] = 1'b0;
    @(negedge CLK);
    n_chk++; if (mem_en[0] !== 1'b0) begin n_fail++; $display("FAIL fetch_c3_idle got=%0b want=0", mem_en[0]); end
    n_chk++; if (if_rdata[0] !== 32'h8C220004) begin n_fail++; $display("FAIL fetch_c3_rdata got=%h want=8c220004", if_rdata[0]); end
  endtask

  task automatic test_contention();
    if_req[0] = 1'b1; if_addr[0] = 32'h14; dm_read[0] = 1'b1; dm_addr[0] = 32'h20;
    sbq.push_back('{0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h55});
    sbq.push_back('{0, 1'b0, 1'b0, 32'h14, 32'h0, mem_fn(32'h14)});
    @(negedge CLK);
    n_chk++; if (mem_addr[0] !== 32'h20 || dm_done[0] !== 1'b0 || pipe_hold[0] !== 1'b1) begin n_fail++; $display("FAIL cont_c1 got addr=%h done=%0b hold=%0b want 20/0/1", mem_addr[0], dm_done[0], pipe_hold[0]); end
    @(negedge CLK);
    n_chk++; if (dm_done[0] !== 1'b1 || pipe_hold[0] !== 1'b1) begin n_fail++; $display("FAIL cont_c2 got done=%0b hold=%0b want 1/1", dm_done[0], pipe_hold[0]); end
    dm_read[0] = 1'b0;
    @(negedge CLK);
    n_chk++; if (mem_en[0] !== 1'b1 || mem_addr[0] !== 32'h14 || if_done[0] !== 1'b0) begin n_fail++; $display("FAIL cont_c3_fetch got en=%0b addr=%h done=%0b want 1/14/0", mem_en[0], mem_addr[0], if_done[0]); end
    n_chk++; if (dm_rdata[0] !== 32'h55 || pipe_hold[0] !== 1'b1) begin n_fail++; $display("FAIL cont_c3_data got rdata=%h hold=%0b want 55/1", dm_rdata[0], pipe_hold[0]); end
    @(negedge CLK);
    n_chk++; if (if_done[0] !== 1'b1) begin n_fail++; $display("FAIL cont_c4_done got=%0b want=1", if_done[0]); end
    if_req[0] = 1'b0;
    @(negedge CLK);
    n_chk++; if (mem_en[0] !== 1'b0) begin n_fail++; $display("FAIL cont_c5_idle got=%0b want=0", mem_en[0]); end
  endtask

  task automatic test_store();
    dm_write[0] = 1'b1; dm_addr[0] = 32'h40; dm_wdata[0] = 32'hDEADBEEF;
    sbq.push_back('{0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 32'h0});
    @(negedge CLK);
    n_chk++; if (mem_we[0] !== 1'b1 || mem_addr[0] !== 32'h40 || mem_wdata[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_c1 got we=%0b addr=%h wdata=%h want 1/40/deadbeef", mem_we[0], mem_addr[0], mem_wdata[0]); end
    dm_wdata[0] = 32'h0;
    @(negedge CLK);
    n_chk++; if (mem_we[0] !== 1'b1 || mem_wdata[0] !== 32'hDEADBEEF || dm_done[0] !== 1'b1) begin n_fail++; $display("FAIL store_c2 got we=%0b wdata=%h done=%0b want 1/deadbeef/1", mem_we[0], mem_wdata[0], dm_done[0]); end
    dm_write[0] = 1'b0;
    @(negedge CLK);
    n_chk++; if (dm_rdata[0] !== 32'h55 || mem_en[0] !== 1'b0) begin n_fail++; $display("FAIL store_c3 got rdata=%h en=%0b want 55/0", dm_rdata[0], mem_en[0]); end
  endtask

  task automatic test_fairness();
    logic [5:0] seq;
    int nc, idle;
    seq = '0; nc = 0; idle = 0;
    dm_read[0] = 1'b1; dm_addr[0] = 32'h80; if_req[0] = 1'b1; if_addr[0] = 32'h90;
    for (int i = 0; i < 4; i++) sbq.push_back('{0, 1'b1, 1'b0, 32'h80, 32'h0, mem_fn(32'h80)});
    sbq.push_back('{0, 1'b0, 1'b0, 32'h90, 32'h0, mem_fn(32'h90)});
    sbq.push_back('{0, 1'b1, 1'b0, 32'h80, 32'h0, mem_fn(32'h80)});
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (!mem_en[0]) idle++;
      if (dm_done[0] || if_done[0]) begin seq = {seq[4:0], dm_done[0]}; nc++; end
    end
    dm_read[0] = 1'b0; if_req[0] = 1'b0;
    n_chk++; if (nc != 6) begin n_fail++; $display("FAIL fair_count got=%0d want=6", nc); end
    n_chk++; if (seq !== 6'b111101) begin n_fail++; $display("FAIL fair_order got=%b want=111101", seq); end
    n_chk++; if (idle != 0) begin n_fail++; $display("FAIL fair_idle got=%0d want=0", idle); end
    @(negedge CLK);
  endtask

  task automatic test_dropped();
    if_req[1] = 1'b1; if_addr[1] = 32'h50;
    sbq.push_back('{1, 1'b0, 1'b0, 32'h50, 32'h0, mem_fn(32'h50)});
    @(negedge CLK);
    n_chk++; if (mem_en[1] !== 1'b1 || mem_addr[1] !== 32'h50) begin n_fail++; $display("FAIL drop_c1 got en=%0b addr=%h want 1/50", mem_en[1], mem_addr[1]); end
    if_req[1] = 1'b0;
    @(negedge CLK);
    n_chk++; if (mem_en[1] !== 1'b1 || if_done[1] !== 1'b0) begin n_fail++; $display("FAIL drop_c2 got en=%0b done=%0b want 1/0", mem_en[1], if_done[1]); end
    @(negedge CLK);
    n_chk++; if (if_done[1] !== 1'b1) begin n_fail++; $display("FAIL drop_c3_done got=%0b want=1", if_done[1]); end
    @(negedge CLK);
    n_chk++; if (mem_en[1] !== 1'b0 || if_rdata[1] !== mem_fn(32'h50)) begin n_fail++; $display("FAIL drop_c4 got en=%0b rdata=%h want 0/%h", mem_en[1], if_rdata[1], mem_fn(32'h50)); end
  endtask

  task automatic test_latency1();
    if_req[2] = 1'b1; if_addr[2] = 32'hA0;
    sbq.push_back('{2, 1'b0, 1'b0, 32'hA0, 32'h0, mem_fn(32'hA0)});
    @(negedge CLK);
    n_chk++; if (if_done[2] !== 1'b1 || mem_addr[2] !== 32'hA0) begin n_fail++; $display("FAIL lat1_c1 got done=%0b addr=%h want 1/a0", if_done[2], mem_addr[2]); end
    if_req[2] = 1'b0; dm_read[2] = 1'b1; dm_addr[2] = 32'hB0;
    sbq.push_back('{2, 1'b1, 1'b0, 32'hB0, 32'h0, mem_fn(32'hB0)});
    @(negedge CLK);
    n_chk++; if (dm_done[2] !== 1'b1 || mem_addr[2] !== 32'hB0) begin n_fail++; $display("FAIL lat1_c2 got done=%0b addr=%h want 1/b0", dm_done[2], mem_addr[2]); end
    dm_read[2] = 1'b0; if_req[2] = 1'b1; if_addr[2] = 32'hC0;
    sbq.push_back('{2, 1'b0, 1'b0, 32'hC0, 32'h0, mem_fn(32'hC0)});
    @(negedge CLK);
    n_chk++; if (if_done[2] !== 1'b1 || mem_addr[2] !== 32'hC0) begin n_fail++; $display("FAIL lat1_c3 got done=%0b addr=%h want 1/c0", if_done[2], mem_addr[2]); end
    if_req[2] = 1'b0;
    @(negedge CLK);
    n_chk++; if (mem_en[2] !== 1'b0) begin n_fail++; $display("FAIL lat1_c4_idle got=%0b want=0", mem_en[2]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int g = 0; g < 3; g++) begin
      rst_n[g] = 1'b0; if_req[g] = 1'b0; dm_read[g] = 1'b0; dm_write[g] = 1'b0;
      if_addr[g] = '0; dm_addr[g] = '0; dm_wdata[g] = '0; dm_hold[g] = '0;
    end
    test_reset();
    test_single_fetch();
    test_contention();
    test_store();
    test_fairness();
    test_dropped();
    test_latency1();
    repeat (3) @(negedge CLK);
    n_chk++; if (sbq.size() != 0 || pend) begin n_fail++; $display("FAIL sb_leftover got=%0d pending want=0", sbq.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
